// File: rtl/intr_prio_ctrl.sv
// Multi-bus interrupt priority controller: edge-captured pending bits, fixed bus priority.
// Define INTC_ROUND_ROBIN_EN for per-bus round-robin channel selection (default: lowest index).
module intr_prio_ctrl #(
    parameter int unsigned NCH  = 9,
    parameter int unsigned NBUS = 3,
    localparam int unsigned IDW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NBUS*NCH-1:0]  req,
    input  logic [NCH-1:0]       mask,
    input  logic                 ack,
    output logic                 gnt_valid,
    output logic [1:0]           gnt_bus,
    output logic [IDW-1:0]       gnt_ch,
    output logic [NBUS*NCH-1:0]  pend,
    output logic                 any_pend
);

    typedef enum logic [1:0] {StIdle, StArb, StGrant} state_e;

    state_e                state_q, state_d;
    logic [NBUS*NCH-1:0]   req_prev_q;
    logic [NBUS*NCH-1:0]   pend_q, pend_d;
    logic                  gnt_valid_q, gnt_valid_d;
    logic [1:0]            gnt_bus_q, gnt_bus_d;
    logic [IDW-1:0]        gnt_ch_q, gnt_ch_d;

    logic [NBUS*NCH-1:0]   rise, clr, eligible;
    logic                  ack_take;
    logic [NCH-1:0]        elig_bus, rot;
    logic                  win_found;
    logic [1:0]            win_bus;
    logic [IDW-1:0]        win_ch;

`ifdef INTC_ROUND_ROBIN_EN
    localparam int unsigned IDW1 = IDW + 1;
    logic [IDW-1:0]        rr_q [NBUS];
    logic [IDW-1:0]        rr_d [NBUS];
    logic [2*NCH-1:0]      dbl;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned off);
        logic [IDW:0] s;
        s = {1'b0, base} + IDW1'(off);
        if (s >= IDW1'(NCH)) s = s - IDW1'(NCH);
        return s[IDW-1:0];
    endfunction
`endif

    assign ack_take = gnt_valid_q && ack;
    assign rise     = req & ~req_prev_q;

    always_comb begin
        eligible = '0;
        clr      = '0;
        for (int unsigned b = 0; b < NBUS; b++) begin
            eligible[b*NCH +: NCH] = pend_q[b*NCH +: NCH] & mask;
            for (int unsigned c = 0; c < NCH; c++) begin
                if (ack_take && gnt_bus_q == 2'(b) && gnt_ch_q == IDW'(c)) begin
                    clr[b*NCH+c] = 1'b1;
                end
            end
        end
        // A new edge in the same cycle as the clearing ack keeps the bit set.
        pend_d = (pend_q & ~clr) | rise;
    end

    // Lowest eligible bus wins; within it, first eligible channel from the search start.
    always_comb begin
        win_found = 1'b0;
        win_bus   = '0;
        win_ch    = '0;
        elig_bus  = '0;
        rot       = '0;
`ifdef INTC_ROUND_ROBIN_EN
        dbl       = '0;
`endif
        for (int unsigned b = 0; b < NBUS; b++) begin
            elig_bus = eligible[b*NCH +: NCH];
`ifdef INTC_ROUND_ROBIN_EN
            dbl = {elig_bus, elig_bus} >> rr_q[b];
            rot = dbl[NCH-1:0];
`else
            rot = elig_bus;
`endif
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!win_found && rot[i]) begin
                    win_found = 1'b1;
                    win_bus   = 2'(b);
`ifdef INTC_ROUND_ROBIN_EN
                    win_ch    = wrap_add(rr_q[b], i);
`else
                    win_ch    = IDW'(i);
`endif
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_valid_d = gnt_valid_q;
        gnt_bus_d   = gnt_bus_q;
        gnt_ch_d    = gnt_ch_q;
        case (state_q)
            StIdle: begin
                if (|eligible) state_d = StArb;
            end
            StArb: begin
                if (win_found) begin
                    state_d     = StGrant;
                    gnt_valid_d = 1'b1;
                    gnt_bus_d   = win_bus;
                    gnt_ch_d    = win_ch;
                end else begin
                    state_d = StIdle;
                end
            end
            StGrant: begin
                if (ack) begin
                    state_d     = StIdle;
                    gnt_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

`ifdef INTC_ROUND_ROBIN_EN
    always_comb begin
        for (int unsigned b = 0; b < NBUS; b++) begin
            rr_d[b] = rr_q[b];
            if (ack_take && gnt_bus_q == 2'(b)) begin
                rr_d[b] = (gnt_ch_q == IDW'(NCH-1)) ? '0 : gnt_ch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NBUS; b++) rr_q[b] <= '0;
        end else begin
            for (int unsigned b = 0; b < NBUS; b++) rr_q[b] <= rr_d[b];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_prev_q  <= '0;
            pend_q      <= '0;
            gnt_valid_q <= 1'b0;
            gnt_bus_q   <= '0;
            gnt_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_prev_q  <= req;
            pend_q      <= pend_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_bus_q   <= gnt_bus_d;
            gnt_ch_q    <= gnt_ch_d;
        end
    end

    assign gnt_valid = gnt_valid_q;
    assign gnt_bus   = gnt_bus_q;
    assign gnt_ch    = gnt_ch_q;
    assign pend      = pend_q;
    assign any_pend  = |pend_q;

endmodule

// File: tb/tb_intr_prio_ctrl.sv
// Scoreboard bench for intr_prio_ctrl (default NCH=9, NBUS=3); honours INTC_ROUND_ROBIN_EN.
module tb_intr_prio_ctrl;

    localparam int NCH  = 9;
    localparam int NBUS = 3;
    localparam int IDW  = $clog2(NCH);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NBUS*NCH-1:0]  req;
    logic [NCH-1:0]       mask;
    logic                 ack;
    logic                 gnt_valid;
    logic [1:0]           gnt_bus;
    logic [IDW-1:0]       gnt_ch;
    logic [NBUS*NCH-1:0]  pend;
    logic                 any_pend;

    int checks = 0;
    int errors = 0;
    logic [IDW+1:0] exp_q[$];
    logic           prev_gv = 1'b0;

    always #5 clk = ~clk;

    intr_prio_ctrl #(.NCH(NCH), .NBUS(NBUS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .ack       (ack),
        .gnt_valid (gnt_valid),
        .gnt_bus   (gnt_bus),
        .gnt_ch    (gnt_ch),
        .pend      (pend),
        .any_pend  (any_pend)
    );

    function automatic logic [IDW+1:0] mk(input int b, input int c);
        return {2'(b), IDW'(c)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_grant();
        for (int n = 0; n < 20 && !gnt_valid; n++) step();
        chk("grant_seen", 64'(gnt_valid), 64'd1);
    endtask

    task automatic serve();
        wait_grant();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    // Monitor: each new grant is compared against the next queued (bus,ch).
    always @(negedge clk) begin
        logic [IDW+1:0] e;
        if (gnt_valid && !prev_gv) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant: got bus %0d ch %0d, queue empty", gnt_bus, gnt_ch);
            end else begin
                e = exp_q.pop_front();
                if ({gnt_bus, gnt_ch} !== e) begin
                    errors++;
                    $display("FAIL grant_order: got bus %0d ch %0d expected bus %0d ch %0d",
                             gnt_bus, gnt_ch, e[IDW+1:IDW], e[IDW-1:0]);
                end
            end
        end
        prev_gv = gnt_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        mask  = '1;
        ack   = 1'b0;
        step();
        step();
        chk("rst_gnt_valid", 64'(gnt_valid), 64'd0);
        chk("rst_pend", 64'(pend), 64'd0);
        chk("rst_any_pend", 64'(any_pend), 64'd0);
        chk("rst_gnt_idx", 64'({gnt_bus, gnt_ch}), 64'd0);
        rst_n = 1'b1;
        step();

        // Single request: two-edge latency, ack clears pend.
        req[3] = 1'b1;
        exp_q.push_back(mk(0, 3));
        step();
        chk("t1_pend_set", 64'(pend), 64'h8);
        chk("t1_any_pend", 64'(any_pend), 64'd1);
        chk("t1_gv_k", 64'(gnt_valid), 64'd0);
        step();
        chk("t1_gv_k1", 64'(gnt_valid), 64'd0);
        step();
        chk("t1_gv_k2", 64'({gnt_valid, gnt_bus, gnt_ch}), 64'({1'b1, mk(0, 3)}));
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t1_gv_after_ack", 64'(gnt_valid), 64'd0);
        chk("t1_pend_clear", 64'(pend), 64'd0);
        req = '0;
        step();

        // Simultaneous edges on three buses: bus priority order.
        req[2*NCH+0] = 1'b1;
        req[0*NCH+8] = 1'b1;
        req[1*NCH+1] = 1'b1;
        exp_q.push_back(mk(0, 8));
        exp_q.push_back(mk(1, 1));
        exp_q.push_back(mk(2, 0));
        serve();
        serve();
        serve();
        chk("t2_pend_drained", 64'(pend), 64'd0);
        req = '0;
        step();

        // Masked pend is held but not granted until unmasked.
        mask[4] = 1'b0;
        req[4]  = 1'b1;
        for (int n = 0; n < 5; n++) step();
        chk("t3_masked_gv", 64'(gnt_valid), 64'd0);
        chk("t3_masked_any_pend", 64'(any_pend), 64'd1);
        exp_q.push_back(mk(0, 4));
        mask[4] = 1'b1;
        step();
        step();
        chk("t3_unmask_gv", 64'(gnt_valid), 64'd1);
        serve();
        req = '0;
        step();

        // No preemption by a higher-priority edge during a grant.
        req[1*NCH+5] = 1'b1;
        exp_q.push_back(mk(1, 5));
        exp_q.push_back(mk(0, 0));
        wait_grant();
        req[0] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t4_hold", 64'({gnt_valid, gnt_bus, gnt_ch}), 64'({1'b1, mk(1, 5)}));
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        serve();
        req = '0;
        step();

        // Ack coinciding with a new edge on the granted bit: set wins, re-grant.
        req[6] = 1'b1;
        exp_q.push_back(mk(0, 6));
        exp_q.push_back(mk(0, 6));
        wait_grant();
        req[6] = 1'b0;
        step();
        req[6] = 1'b1;
        ack    = 1'b1;
        step();
        ack = 1'b0;
        chk("t5_pend_kept", 64'(pend[6]), 64'd1);
        chk("t5_gv_e0", 64'(gnt_valid), 64'd0);
        step();
        chk("t5_gv_e1", 64'(gnt_valid), 64'd0);
        step();
        chk("t5_gv_e2", 64'(gnt_valid), 64'd1);
        serve();
        req = '0;
        step();

        // Two channels re-triggered on every ack: fairness depends on build.
`ifdef INTC_ROUND_ROBIN_EN
        for (int n = 0; n < 3; n++) begin
            exp_q.push_back(mk(0, 1));
            exp_q.push_back(mk(0, 2));
        end
`else
        for (int n = 0; n < 5; n++) exp_q.push_back(mk(0, 1));
        exp_q.push_back(mk(0, 2));
`endif
        req[1] = 1'b1;
        req[2] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_grant();
            req[1] = 1'b0;
            req[2] = 1'b0;
            step();
            req[1] = 1'b1;
            req[2] = 1'b1;
            ack    = 1'b1;
            step();
            ack = 1'b0;
        end
        serve();
        serve();
        chk("t6_pend_drained", 64'(pend), 64'd0);
        req = '0;
        step();

        // Asynchronous reset mid-grant, then a request held through release.
        req[2*NCH+3] = 1'b1;
        exp_q.push_back(mk(2, 3));
        wait_grant();
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async_gv", 64'(gnt_valid), 64'd0);
        chk("t7_async_pend", 64'(pend), 64'd0);
        step();
        rst_n = 1'b1;
        exp_q.push_back(mk(2, 3));
        serve();
        chk("t7_pend_drained", 64'(pend), 64'd0);
        req = '0;
        for (int n = 0; n < 4; n++) step();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intr_prio_ctrl.md
INTR_PRIO_CTRL -- requirements
Module: intr_prio_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 9: channels per bus, legal range 2..32.
REQ-002 SHALL have parameter NBUS, default 3: request buses, legal range 1..4, bus 0 highest priority.
REQ-003 SHALL have parameter IDW, default ceil(log2(NCH)): channel index width, derived only, never overridden.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  NBUS*NCH  level requests; bit b*NCH+c is bus b, channel c.
REQ-007 SHALL have port mask  input  NCH  per-channel enable (1 = enabled), applied to every bus.
REQ-008 SHALL have port ack  input  1  consumer accepts the current grant.
REQ-009 SHALL have port gnt_valid  output  1  grant outstanding.
REQ-010 SHALL have port gnt_bus  output  2  granted bus index; bits at or above NBUS always 0.
REQ-011 SHALL have port gnt_ch  output  IDW  granted channel index.
REQ-012 SHALL have port pend  output  NBUS*NCH  pending register, same bit layout as req.
REQ-013 SHALL have port any_pend  output  1  OR of all pend bits.

Function
REQ-014 SHALL register req into req_d each cycle; a rising edge (req=1, req_d=0) at clock edge k sets the matching pend bit after edge k, regardless of mask.
REQ-015 SHALL clear a pend bit only on ack of its grant; if a new rising edge on that bit occurs in the same cycle, set wins.
REQ-016 SHALL compute eligible = pend AND mask replicated across all buses.
REQ-017 SHALL implement FSM states IDLE, ARB, GRANT.
REQ-018 IDLE: if any eligible bit is 1, next state ARB; otherwise stay in IDLE.
REQ-019 ARB winner: lowest bus index with an eligible bit, then lowest channel index within that bus; register gnt_bus/gnt_ch, set gnt_valid, next state GRANT.
REQ-020 ARB with no eligible bit (masked meanwhile): return to IDLE, gnt_valid stays 0.
REQ-021 GRANT: gnt_bus/gnt_ch/gnt_valid held stable; no preemption by new higher-priority pends; masking the granted channel does not withdraw the grant.
REQ-022 GRANT with ack=1: clear the granted pend bit, gnt_valid=0 after the edge, next state IDLE.
REQ-023 SHALL ignore ack while gnt_valid=0.
REQ-024 Latency: req edge sampled at edge k gives state ARB after k+1 and gnt_valid=1 after k+2; minimum spacing between successive grants is 3 cycles.
REQ-025 any_pend SHALL be combinational from the pend register only.

Reset
REQ-026 rst_n low SHALL asynchronously force pend=0, req_d=0, state=IDLE, gnt_valid=0, gnt_bus=0, gnt_ch=0, all round-robin pointers=0.
REQ-027 Reset mid-grant SHALL drop gnt_valid immediately without waiting for a clock edge.
REQ-028 A req bit held high through reset release SHALL be captured as a rising edge at the first clock edge after release.

Configuration
REQ-029 Macro INTC_ROUND_ROBIN_EN defined: one IDW-bit pointer rr[b] per bus; the channel search in the winning bus starts at rr[b] and wraps; on ack, rr[gnt_bus] = (gnt_ch+1) mod NCH; bus priority stays fixed.
REQ-030 Macro INTC_ROUND_ROBIN_EN undefined: fixed lowest-index channel priority, and no pointer registers are instantiated.

Verification
REQ-031 Reset, then rising edge on bus0 ch3 at edge 2 -> gnt_valid=1, gnt_bus=0, gnt_ch=3 after edge 4; ack at edge 6 -> gnt_valid=0 and pend[3]=0 after edge 6.
REQ-032 Simultaneous rising edges on bus2 ch0, bus0 ch8, bus1 ch1 -> grants issued in order (0,8), (1,1), (2,0), with one ack per grant.
REQ-033 pend set on bus0 ch4 with mask[4]=0 -> no grant and any_pend=1; set mask[4]=1 -> gnt_valid=1 within 2 cycles.
REQ-034 While granting (1,5), new rising edge on bus0 ch0 -> grant stays (1,5) until ack; the next grant is (0,0).
REQ-035 Ack in the same cycle as a new rising edge on the granted bit -> pend stays 1 and the same (bus,ch) is granted again 3 cycles later.
REQ-036 Bus0 ch1 and ch2 both re-triggered before every ack -> with INTC_ROUND_ROBIN_EN the grants alternate 1,2,1,2; without it every grant is ch1.
